// File: rtl/elastic_stage_pipe_pkg.sv
// Shared sizing helpers for elastic pipe blocks.
// Stage capacity and occupancy counter width.
package elastic_stage_pipe_pkg;

  localparam int SKID_CAP  = 2;
  localparam int PLAIN_CAP = 1;

  function automatic int stage_cap(input int skid);
    return (skid != 0) ? SKID_CAP : PLAIN_CAP;
  endfunction

  function automatic int occ_w(input int depth,
                               input int skid);
    return $clog2(stage_cap(skid) * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage_pipe_stage.sv
// One elastic valid/ready stage, optionally with a
// skid register so that upstream ready is registered.
module elastic_stage #(
  parameter int WIDTH      = 32,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Flush,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_Data,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Data
);

  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = i_Valid & o_Ready;
  assign w_out_fire = r_m_valid & i_Ready;
  assign o_Valid    = r_m_valid;
  assign o_Data     = r_m_data;

  generate
    if (SKID != 0) begin : g_skid
      logic             r_s_valid;
      logic [WIDTH-1:0] r_s_data;

      assign o_Ready = !r_s_valid;

      // Skid only fills while main is stalled; it drains first.
      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
          if (CLEAR_DATA != 0) begin
            r_m_data <= '0;
            r_s_data <= '0;
          end
        end else if (i_Flush) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
          if (CLEAR_DATA != 0) begin
            r_m_data <= '0;
            r_s_data <= '0;
          end
        end else if (!r_m_valid || w_out_fire) begin
          if (r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
          end else begin
            r_m_valid <= w_in_fire;
            if (w_in_fire) r_m_data <= i_Data;
          end
        end else if (w_in_fire) begin
          r_s_valid <= 1'b1;
          r_s_data  <= i_Data;
        end
      end
    end else begin : g_plain
      assign o_Ready = !r_m_valid || i_Ready;

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          r_m_valid <= 1'b0;
          if (CLEAR_DATA != 0) r_m_data <= '0;
        end else if (i_Flush) begin
          r_m_valid <= 1'b0;
          if (CLEAR_DATA != 0) r_m_data <= '0;
        end else if (w_in_fire) begin
          r_m_valid <= 1'b1;
          r_m_data  <= i_Data;
        end else if (w_out_fire) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/elastic_stage_pipe.sv
// Chain of DEPTH elastic stages with flush and a
// registered occupancy count.
module elastic_stage_pipe
  import elastic_stage_pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_n,
  input  logic                          i_Flush,
  input  logic                          i_Valid,
  output logic                          o_Ready,
  input  logic [WIDTH-1:0]              i_Data,
  output logic                          o_Valid,
  input  logic                          i_Ready,
  output logic [WIDTH-1:0]              o_Data,
  output logic [occ_w(DEPTH,SKID)-1:0]  o_Occupancy
);

  localparam int OCC_W = occ_w(DEPTH, SKID);

  logic             w_valid [DEPTH+1];
  logic             w_ready [DEPTH+1];
  logic [WIDTH-1:0] w_data  [DEPTH+1];
  logic             w_acc;
  logic             w_emit;
  logic [OCC_W-1:0] r_occ;

  assign w_valid[0]     = i_Valid;
  assign w_data[0]      = i_Data;
  assign w_ready[DEPTH] = i_Ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_st
    elastic_stage #(
      .WIDTH      (WIDTH),
      .SKID       (SKID),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_stage (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Flush (i_Flush),
      .i_Valid (w_valid[k]),
      .o_Ready (w_ready[k]),
      .i_Data  (w_data[k]),
      .o_Valid (w_valid[k+1]),
      .i_Ready (w_ready[k+1]),
      .o_Data  (w_data[k+1])
    );
  end

  // Stages clear themselves on flush, so gating here suffices.
  assign o_Ready = w_ready[0] & i_Rst_n & !i_Flush;
  assign o_Valid = w_valid[DEPTH];
  assign o_Data  = w_data[DEPTH];

  assign w_acc  = i_Valid & o_Ready;
  assign w_emit = o_Valid & i_Ready;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_occ <= '0;
    end else if (i_Flush) begin
      r_occ <= '0;
    end else if (w_acc && !w_emit) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_acc && w_emit) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign o_Occupancy = r_occ;

endmodule

// File: doc/elastic_stage_pipe.md
Name: elastic_stage_pipe

Overview:
Parametrised successor to the single enable/clear pipeline register. It is a chain of DEPTH elastic stages with valid/ready handshaking, a synchronous flush and an occupancy count. It sits between CPU pipeline sections and bus/peripheral datapaths wherever back-pressure must be absorbed without dropping or duplicating beats. Throughput is one beat per clock in steady state.

Parameters:
WIDTH, 32, data bits per beat
DEPTH, 2, number of elastic stages (>=1)
SKID, 1, 1: each stage has main+skid register so upstream ready is registered; 0: single register per stage, ready passes combinationally
CLEAR_DATA, 1, 1: flush/reset also zero data registers; 0: only valid bits cleared

Ports:
i_Clk  in  1  clock, all state on rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Flush  in  1  synchronous flush of all stages
i_Valid  in  1  upstream beat valid
o_Ready  out  1  pipe can accept a beat this cycle
i_Data  in  WIDTH  upstream beat data
o_Valid  out  1  head beat valid
i_Ready  in  1  downstream accepts head beat
o_Data  out  WIDTH  head beat data
o_Occupancy  out  $clog2(STAGE_CAP*DEPTH+1)  beats held; STAGE_CAP = SKID?2:1

Behaviour:
- Reset, async on i_Rst_n low: all valid bits 0, data regs 0, o_Valid=0, o_Data=0, o_Occupancy=0. o_Ready is forced 0 while i_Rst_n is low. o_Ready=1 in the first cycle after release.
- Transfer rule: a beat moves on any interface only when valid&&ready are both high at a rising edge. A valid beat's data must be held stable until it transfers; the pipe never retracts o_Valid.
- Stage k, SKID=0:
  - ready_in_k = !valid_k || ready_out_k.
  - On transfer in, the reg loads data and valid_k=1.
  - On transfer out with no transfer in, valid_k=0.
- Stage k, SKID=1:
  - ready_in_k = !skid_valid_k, registered.
  - Accept while main is full and downstream not ready -> beat goes to skid.
  - When downstream takes main, skid moves to main in the same edge; skid valid clears.
  - Order is always main before skid.
- Latency: a beat accepted at edge N is presented on o_Valid/o_Data after edge N+DEPTH-1, i.e. DEPTH cycles from accept, when unstalled.
- Throughput: with i_Valid=i_Ready=1 continuously, one beat per cycle, no bubbles, for both SKID values.
- Back-pressure: with i_Ready=0, the pipe fills to STAGE_CAP*DEPTH beats, then o_Ready=0. No beat is lost, duplicated or reordered.
- Flush:
  - While i_Flush=1, o_Ready is forced 0; no input accept.
  - An output handshake in the flush cycle counts as completed.
  - At the edge, all valid bits clear; data clears if CLEAR_DATA=1.
  - o_Occupancy=0 the next cycle.
  - Flush has priority over every stage's load.
- o_Occupancy is the registered count of set valid bits. It changes by +1 on accept-only, -1 on emit-only, 0 on both, and goes to 0 on flush.
- SKID=0 has a combinational path i_Ready->o_Ready through all stages. This is documented and permitted.
- Reset mid-stream: all beats discarded immediately (async), with no partial beat emitted.

Decomposition:
- Shared package/header: stage capacity localparam, occupancy width function (clog2) reused by other pipe blocks.
- One natural sub-module, elastic_stage: one stage with WIDTH, SKID, CLEAR_DATA parameters and valid/ready in/out plus flush.
- The top generates a chain of DEPTH instances and the occupancy counter.

Test Plan:
- Reset release, DEPTH=2, SKID=1 -> o_Ready=1, o_Valid=0, o_Data=0, o_Occupancy=0. Beat 0xA5A5A5A5 accepted at edge 1 appears at o_Valid after edge 2.
- Stream 0..99 with i_Valid=i_Ready=1, both SKID values -> output 0..99 in order, one per cycle after DEPTH latency, o_Occupancy steady at DEPTH.
- Hold i_Ready=0, offer 10 beats, DEPTH=2, SKID=1 -> exactly 4 accepted, o_Ready=0, o_Occupancy=4. Release i_Ready -> beats 0..3 emerge in order, none duplicated.
- Random i_Valid/i_Ready at 50% each over 10k beats -> scoreboard matches in order, o_Occupancy always equals scoreboard depth, never exceeds 2*DEPTH.
- Pipe holding 3 beats, assert i_Flush with i_Valid=1 and i_Ready=1 -> o_Ready=0, head beat consumed, next cycle o_Valid=0, o_Occupancy=0; with CLEAR_DATA=1, o_Data=0.
- Assert i_Rst_n low asynchronously mid-cycle while full -> o_Valid, o_Ready and o_Occupancy fall to 0 before the next edge; recovery accepts new data cleanly.
